// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
// Imported by the interface, the priority selector and the top level.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        D    = 2'd2
    } owner_t;

    localparam logic [2:0] FETCH_SIZE = 3'd2;
    localparam int         FETCH_W    = 32;
    localparam int         STREAK_W   = 4;

    // Data-win streak update: counts only while a fetch is being held off.
    function automatic logic [STREAK_W-1:0] streak_step(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] max_val,
        input logic                fetch_waiting
    );
        if (!fetch_waiting) begin
            return '0;
        end
        return (cur >= max_val) ? max_val : cur + STREAK_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals around the arbiter.
// master = arbiter view, slave = core/memory environment view.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic               i_valid;
    logic [ADDR_W-1:0]  i_addr;
    logic               i_abort;
    logic               i_rvalid;
    logic [FETCH_W-1:0] i_rdata;

    logic               d_valid;
    logic [ADDR_W-1:0]  d_addr;
    logic [2:0]         d_size;
    logic [7:0]         d_strobe;
    logic [DATA_W-1:0]  d_wdata;
    logic               d_rvalid;
    logic [DATA_W-1:0]  d_rdata;

    logic               m_valid;
    logic [ADDR_W-1:0]  m_addr;
    logic [2:0]         m_size;
    logic [7:0]         m_strobe;
    logic [DATA_W-1:0]  m_wdata;
    logic               m_ready;
    logic               m_rvalid;
    logic [DATA_W-1:0]  m_rdata;

    modport master (
        input  i_valid, i_addr, i_abort,
        output i_rvalid, i_rdata,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        output d_rvalid, d_rdata,
        output m_valid, m_addr, m_size, m_strobe, m_wdata,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        output i_valid, i_addr, i_abort,
        input  i_rvalid, i_rdata,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  d_rvalid, d_rdata,
        input  m_valid, m_addr, m_size, m_strobe, m_wdata,
        output m_ready, m_rvalid, m_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_priority.sv
// Winner select for an idle port: data has priority unless a waiting fetch
// has already lost MAX_DSTREAK times in a row.
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
)
(
    input  logic                i_d_valid,
    input  logic                i_i_valid,
    input  logic                i_i_abort,
    input  logic [STREAK_W-1:0] i_streak,
    output logic                o_grant_d,
    output logic                o_grant_i
);

    logic w_fetch_due;

    assign w_fetch_due = i_i_valid && (i_streak == STREAK_W'(MAX_DSTREAK));

    // A redirecting fetch cannot win, but it still blocks data when fetch is due.
    assign o_grant_d = i_d_valid && !w_fetch_due;
    assign o_grant_i = !o_grant_d && i_i_valid && !i_i_abort;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat memory port between instruction fetch and data access,
// with bounded fetch starvation and a discard path for redirected fetches.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
)
(
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);

    arb_state_t          r_state;
    owner_t              r_owner;
    logic [STREAK_W-1:0] r_streak;
    logic                r_discard;
    logic                r_m_valid;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [2:0]          r_m_size;
    logic [7:0]          r_m_strobe;
    logic [DATA_W-1:0]   r_m_wdata;

    arb_state_t          w_state_next;
    owner_t              w_owner_next;
    logic [STREAK_W-1:0] w_streak_next;
    logic                w_discard_next;
    logic                w_m_valid_next;
    logic [ADDR_W-1:0]   w_m_addr_next;
    logic [2:0]          w_m_size_next;
    logic [7:0]          w_m_strobe_next;
    logic [DATA_W-1:0]   w_m_wdata_next;

    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_resp_fire;
    logic                w_i_hit;
    logic                w_d_hit;
    logic [FETCH_W-1:0]  w_fetch_word;

    arb_priority #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_priority (
        .i_d_valid (bus.d_valid),
        .i_i_valid (bus.i_valid),
        .i_i_abort (bus.i_abort),
        .i_streak  (r_streak),
        .o_grant_d (w_grant_d),
        .o_grant_i (w_grant_i)
    );

    // A response only counts while a transaction is in flight; stray beats in IDLE are dropped.
    assign w_resp_fire = bus.m_rvalid &&
                         (((r_state == REQ) && bus.m_ready) || (r_state == WAIT));

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_streak_next   = r_streak;
        w_discard_next  = r_discard;
        w_m_valid_next  = r_m_valid;
        w_m_addr_next   = r_m_addr;
        w_m_size_next   = r_m_size;
        w_m_strobe_next = r_m_strobe;
        w_m_wdata_next  = r_m_wdata;

        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next    = REQ;
                    w_owner_next    = D;
                    w_m_valid_next  = 1'b1;
                    w_m_addr_next   = bus.d_addr;
                    w_m_size_next   = bus.d_size;
                    w_m_strobe_next = bus.d_strobe;
                    w_m_wdata_next  = bus.d_wdata;
                    w_streak_next   = streak_step(r_streak, STREAK_W'(MAX_DSTREAK), bus.i_valid);
                end else if (w_grant_i) begin
                    w_state_next    = REQ;
                    w_owner_next    = I;
                    w_m_valid_next  = 1'b1;
                    w_m_addr_next   = bus.i_addr;
                    w_m_size_next   = FETCH_SIZE;
                    w_m_strobe_next = '0;
                    w_m_wdata_next  = '0;
                    w_streak_next   = '0;
                end
            end

            REQ: begin
                if (bus.i_abort && (r_owner == I)) begin
                    w_discard_next = 1'b1;
                end
                if (bus.m_ready) begin
                    w_m_valid_next = 1'b0;
                    w_state_next   = WAIT;
                    if (bus.m_rvalid) begin
                        w_state_next   = IDLE;
                        w_owner_next   = NONE;
                        w_discard_next = 1'b0;
                    end
                end
            end

            WAIT: begin
                if (bus.i_abort && (r_owner == I)) begin
                    w_discard_next = 1'b1;
                end
                if (bus.m_rvalid) begin
                    w_state_next   = IDLE;
                    w_owner_next   = NONE;
                    w_discard_next = 1'b0;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_owner_next = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= NONE;
            r_streak   <= '0;
            r_discard  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_addr   <= '0;
            r_m_size   <= '0;
            r_m_strobe <= '0;
            r_m_wdata  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_streak   <= w_streak_next;
            r_discard  <= w_discard_next;
            r_m_valid  <= w_m_valid_next;
            r_m_addr   <= w_m_addr_next;
            r_m_size   <= w_m_size_next;
            r_m_strobe <= w_m_strobe_next;
            r_m_wdata  <= w_m_wdata_next;
        end
    end

    // Response routing is combinational; read data is zeroed whenever its valid is low.
    assign w_i_hit      = w_resp_fire && (r_owner == I) && !r_discard && !bus.i_abort;
    assign w_d_hit      = w_resp_fire && (r_owner == D);
    assign w_fetch_word = r_m_addr[2] ? bus.m_rdata[DATA_W-1 -: FETCH_W]
                                      : bus.m_rdata[FETCH_W-1:0];

    assign bus.i_rvalid = w_i_hit;
    assign bus.i_rdata  = w_i_hit ? w_fetch_word : '0;
    assign bus.d_rvalid = w_d_hit;
    assign bus.d_rdata  = w_d_hit ? bus.m_rdata : '0;

    assign bus.m_valid  = r_m_valid;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_size   = r_m_size;
    assign bus.m_strobe = r_m_strobe;
    assign bus.m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requesters and a memory model
// feed expected grants/responses into queues that a negedge monitor checks.
module tb_mem_bus_arbiter;

    localparam int ADDR_W      = 64;
    localparam int DATA_W      = 64;
    localparam int MAX_DSTREAK = 4;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_bus_arbiter #(
        .MAX_DSTREAK (MAX_DSTREAK),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    req_t        exp_g[$];
    logic [31:0] exp_i[$];
    logic [63:0] exp_d[$];
    logic [63:0] rsp_q[$];
    logic [63:0] fq[$];
    req_t        dq[$];

    bit i_done = 1'b0;
    bit d_done = 1'b0;

    int rdy_lat    = 0;
    int rsp_lat    = 1;
    bit same_cycle = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return bus.m_valid && bus.m_ready;
            1:       return bus.m_rvalid;
            2:       return bus.d_rvalid;
            3:       return bus.m_valid;
            default: return bus.i_rvalid;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cond(sel)) return;
        end
        check({"timeout ", name}, 256'(cond(sel)), 256'(1));
    endtask

    task automatic drain(input string name);
        int pend;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            pend = exp_g.size() + exp_i.size() + exp_d.size() + fq.size() + dq.size()
                 + int'(bus.i_valid) + int'(bus.d_valid) + int'(bus.m_valid);
            if (pend == 0) begin
                @(negedge clk);
                return;
            end
        end
        check({"drain ", name}, 256'(pend), '0);
    endtask

    task automatic check_zero(input string name);
        check(name, 256'({bus.m_valid, bus.m_addr, bus.m_size, bus.m_strobe, bus.m_wdata,
                          bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata}), '0);
    endtask

    // Fetch requester: holds i_valid until its response (or an abort) is seen.
    initial begin : fetch_drv
        bus.i_valid = 1'b0;
        bus.i_addr  = '0;
        forever begin
            @(posedge clk); #1;
            if (reset || i_done) begin
                bus.i_valid = 1'b0;
                i_done      = 1'b0;
            end
            if (!reset && !bus.i_valid && fq.size() > 0) begin
                bus.i_valid = 1'b1;
                bus.i_addr  = fq.pop_front();
            end
        end
    end

    initial begin : data_drv
        req_t r;
        bus.d_valid  = 1'b0;
        bus.d_addr   = '0;
        bus.d_size   = '0;
        bus.d_strobe = '0;
        bus.d_wdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (reset || d_done) begin
                bus.d_valid = 1'b0;
                d_done      = 1'b0;
            end
            if (!reset && !bus.d_valid && dq.size() > 0) begin
                r            = dq.pop_front();
                bus.d_valid  = 1'b1;
                bus.d_addr   = r.addr;
                bus.d_size   = r.size;
                bus.d_strobe = r.strobe;
                bus.d_wdata  = r.wdata;
            end
        end
    end

    // Memory model: ready after rdy_lat cycles, response rsp_lat cycles later or with ready.
    initial begin : mem_model
        int  wait_cnt;
        int  rsp_cnt;
        bit  pending;
        wait_cnt = 0;
        rsp_cnt  = 0;
        pending  = 1'b0;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            bus.m_ready  = 1'b0;
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = '0;
            if (pending) begin
                if (rsp_cnt == 0) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 64'h0;
                    pending      = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end else if (bus.m_valid) begin
                if (wait_cnt >= rdy_lat) begin
                    bus.m_ready = 1'b1;
                    wait_cnt    = 0;
                    if (same_cycle) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rdata  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 64'h0;
                    end else begin
                        pending = 1'b1;
                        rsp_cnt = rsp_lat - 1;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin : monitor
        req_t got;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (bus.m_valid && bus.m_ready) begin
                    got.addr   = bus.m_addr;
                    got.size   = bus.m_size;
                    got.strobe = bus.m_strobe;
                    got.wdata  = bus.m_wdata;
                    $display("[TB] grant addr=%h size=%0d strobe=%h wdata=%h",
                             got.addr, got.size, got.strobe, got.wdata);
                    if (exp_g.size() == 0) check("unexpected grant", 256'(bus.m_valid), '0);
                    else                   check("grant fields", 256'(got), 256'(exp_g.pop_front()));
                end
                if (bus.i_rvalid) begin
                    i_done = 1'b1;
                    $display("[TB] fetch response i_rdata=%h", bus.i_rdata);
                    if (exp_i.size() == 0) check("unexpected i_rvalid", 256'(bus.i_rvalid), '0);
                    else                   check("i_rdata", 256'(bus.i_rdata), 256'(exp_i.pop_front()));
                end
                if (bus.d_rvalid) begin
                    d_done = 1'b1;
                    $display("[TB] data response d_rdata=%h", bus.d_rdata);
                    if (exp_d.size() == 0) check("unexpected d_rvalid", 256'(bus.d_rvalid), '0);
                    else                   check("d_rdata", 256'(bus.d_rdata), 256'(exp_d.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests_run);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        req_t r;
        bus.i_abort = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 check_zero("reset outputs");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Fetch only, upper word selected by addr[2]
        @(negedge clk);
        rdy_lat = 1; rsp_lat = 2; same_cycle = 1'b0;
        exp_g.push_back('{addr: 64'h8000_0004, size: 3'd2, strobe: 8'h00, wdata: 64'h0});
        rsp_q.push_back(64'h1111_2222_3333_4444);
        exp_i.push_back(32'h1111_2222);
        fq.push_back(64'h8000_0004);
        wait_cond(4, "fetch i_rvalid");
        @(negedge clk);
        check("fetch i_rvalid one cycle", 256'(bus.i_rvalid), '0);
        drain("fetch");

        // Simultaneous: data first, fetch re-granted in the IDLE cycle after d_rvalid
        rdy_lat = 0; rsp_lat = 1;
        r = '{addr: 64'h0000_1000, size: 3'd3, strobe: 8'hFF, wdata: 64'hDEAD};
        exp_g.push_back(r);
        exp_g.push_back('{addr: 64'h8000_0010, size: 3'd2, strobe: 8'h00, wdata: 64'h0});
        rsp_q.push_back(64'h0123_4567_89AB_CDEF);
        rsp_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        exp_d.push_back(64'h0123_4567_89AB_CDEF);
        exp_i.push_back(32'hCCCC_DDDD);
        dq.push_back(r);
        fq.push_back(64'h8000_0010);
        wait_cond(2, "simultaneous d_rvalid");
        @(negedge clk);
        check("simultaneous idle gap m_valid", 256'(bus.m_valid), '0);
        @(negedge clk);
        check("simultaneous fetch regrant", 256'({bus.m_valid, bus.m_addr}), 256'({1'b1, 64'h8000_0010}));
        drain("simultaneous");

        // Starvation bound: D,D,D,D,I,D,D,I with both sides held high
        for (int k = 0; k < 6; k++) begin
            r = '{addr: 64'h2000 + 64'(8 * k), size: 3'd3, strobe: 8'h00, wdata: 64'h0};
            dq.push_back(r);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                exp_g.push_back('{addr: 64'h8000_0100, size: 3'd2, strobe: 8'h00, wdata: 64'h0});
                rsp_q.push_back(64'hF1F1_F1F1_1234_5678);
                exp_i.push_back(32'h1234_5678);
            end else if (k == 7) begin
                exp_g.push_back('{addr: 64'h8000_0104, size: 3'd2, strobe: 8'h00, wdata: 64'h0});
                rsp_q.push_back(64'h9876_5432_F2F2_F2F2);
                exp_i.push_back(32'h9876_5432);
            end else begin
                int dk;
                dk = (k < 4) ? k : k - 1;
                exp_g.push_back('{addr: 64'h2000 + 64'(8 * dk), size: 3'd3, strobe: 8'h00, wdata: 64'h0});
                rsp_q.push_back(64'hD0D0_0000_0000_0000 | 64'(dk));
                exp_d.push_back(64'hD0D0_0000_0000_0000 | 64'(dk));
            end
        end
        fq.push_back(64'h8000_0100);
        fq.push_back(64'h8000_0104);
        drain("starvation");

        // Abort while the fetch waits for its response
        rdy_lat = 0; rsp_lat = 3;
        exp_g.push_back('{addr: 64'h8000_0200, size: 3'd2, strobe: 8'h00, wdata: 64'h0});
        rsp_q.push_back(64'h5555_5555_5555_5555);
        fq.push_back(64'h8000_0200);
        wait_cond(0, "abort fetch accept");
        @(posedge clk); #1;
        bus.i_abort = 1'b1;
        i_done      = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        wait_cond(1, "abort m_rvalid");
        check("abort suppresses i_rvalid", 256'(bus.i_rvalid), '0);
        @(negedge clk);
        r = '{addr: 64'h0000_3000, size: 3'd3, strobe: 8'h0F, wdata: 64'h77};
        exp_g.push_back(r);
        rsp_q.push_back(64'h4444);
        exp_d.push_back(64'h4444);
        dq.push_back(r);
        drain("abort");

        // Stalling memory, then same-cycle ready + response
        rdy_lat = 5; same_cycle = 1'b1;
        r = '{addr: 64'h4000_0008, size: 3'd3, strobe: 8'hF0, wdata: 64'hCAFE_F00D_0000_BEEF};
        exp_g.push_back(r);
        rsp_q.push_back(64'h6666_7777_8888_9999);
        exp_d.push_back(64'h6666_7777_8888_9999);
        dq.push_back(r);
        wait_cond(3, "stall m_valid");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("stall hold %0d", k),
                  256'({bus.m_valid, bus.m_addr, bus.m_wdata}),
                  256'({1'b1, 64'h4000_0008, 64'hCAFE_F00D_0000_BEEF}));
        end
        drain("stall");
        same_cycle = 1'b0;

        // Async reset mid-WAIT; the stale response afterwards must go nowhere
        rdy_lat = 0; rsp_lat = 4;
        exp_g.push_back('{addr: 64'h8000_0300, size: 3'd2, strobe: 8'h00, wdata: 64'h0});
        rsp_q.push_back(64'hBAD0_BAD0_BAD0_BAD0);
        fq.push_back(64'h8000_0300);
        wait_cond(0, "reset fetch accept");
        @(posedge clk); #3;
        reset = 1'b1;
        #1 check_zero("async reset mid-WAIT");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_cond(1, "stale m_rvalid");
        check("stale response dropped", 256'({bus.i_rvalid, bus.d_rvalid}), '0);
        drain("reset");

        check("scoreboard empty", 256'(exp_g.size() + exp_i.size() + exp_d.size() + rsp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester and the data (load/store) requester of the 5-stage pipeline core.
- Sits between the core's fetch/memory stages and the external memory bus.
- Performs single-beat request/response transactions.
- Grants the data side by fixed priority, with a bounded-starvation guarantee for instruction fetch and a fetch-abort path for pipeline redirects.

Parameters:
MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win (1..15)
ADDR_W, 64, address width
DATA_W, 64, memory data width (fetch data is fixed 32)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_valid  in  1  fetch request; held high until i_rvalid (or i_abort)
i_addr  in  ADDR_W  fetch address, 4-byte aligned
i_abort  in  1  pipeline redirect: discard any outstanding fetch
i_rvalid  out  1  fetch response valid (single cycle)
i_rdata  out  32  fetched instruction
d_valid  in  1  data request; held high until d_rvalid
d_addr  in  ADDR_W  data address
d_size  in  3  access size code, forwarded unchanged
d_strobe  in  8  byte write enables; 0 = read
d_wdata  in  DATA_W  store data
d_rvalid  out  1  data response valid (single cycle)
d_rdata  out  DATA_W  load data
m_valid  out  1  memory request valid (registered)
m_addr  out  ADDR_W  latched address
m_size  out  3  latched size (3'd2 for fetch)
m_strobe  out  8  latched strobe (0 for fetch)
m_wdata  out  DATA_W  latched store data (0 for fetch)
m_ready  in  1  memory accepts request this cycle
m_rvalid  in  1  memory response valid
m_rdata  in  DATA_W  memory response data

Behaviour:
- Reset (async): state=IDLE, owner=NONE, streak=0, discard=0. All outputs 0.
- States are IDLE, REQ and WAIT.
- IDLE:
  - Request selection: if d_valid and not (i_valid and streak==MAX_DSTREAK), grant D; else if i_valid and not i_abort, grant I.
  - On grant: latch the winner's fields into the m_* registers, set m_valid=1 on the next edge, go to REQ.
- REQ:
  - m_valid held high and m_* stable until m_ready.
  - On m_ready: m_valid<=0, go to WAIT.
  - m_rvalid in the same cycle as m_ready is legal: go straight to IDLE with the response delivered.
- WAIT: on m_rvalid, deliver the response and go to IDLE. Memory responses arriving in IDLE are ignored.
- Response routing is combinational, zero added latency:
  - i_rvalid = m_rvalid & owner==I & ~discard & ~i_abort.
  - i_rdata = m_rdata[63:32] if latched addr[2]==1, else m_rdata[31:0].
  - d_rvalid = m_rvalid & owner==D; d_rdata = m_rdata.
- Abort:
  - i_abort while owner==I in REQ/WAIT sets discard.
  - The transaction still completes on the bus (no cancel).
  - The response is suppressed, and discard and owner clear on that m_rvalid.
  - i_abort in IDLE blocks a fetch grant that cycle only.
- Streak counter:
  - On a D grant with i_valid high: streak<=streak+1, saturating at MAX_DSTREAK.
  - Any I grant, or a D grant with i_valid low: streak<=0.
- Back-to-back: the earliest re-grant is the cycle after the response. A requester still asserting valid the cycle after its rvalid issues a new request.
- No re-arbitration mid-transaction; at most one outstanding transaction.

Decomposition:
- Package mem_arb_pkg (alongside common/pipes): arb_state_t enum {IDLE, REQ, WAIT}, owner_t enum {NONE, I, D}, FETCH_SIZE constant (3'd2).
- One natural sub-module, arb_priority: combinational winner select from d_valid, i_valid, i_abort, streak.
- Top level holds the FSM, latches and routing.

Test Plan:
- Fetch only:
  - i_valid=1, i_addr=0x8000_0004, m_ready the cycle after m_valid, m_rvalid 2 cycles later with m_rdata=0x1111_2222_3333_4444.
  - Expect m_addr=0x8000_0004, m_strobe=0, m_size=2, then i_rvalid=1 with i_rdata=0x1111_2222 for exactly one cycle.
- Simultaneous request:
  - i_valid and d_valid together, d_strobe=0xFF, d_wdata=0xDEAD.
  - Expect D granted first (m_wdata=0xDEAD), I granted in the IDLE cycle after d_rvalid.
- Starvation bound with MAX_DSTREAK=4:
  - d_valid and i_valid held high continuously.
  - Expect grants D,D,D,D,I,D..., with the streak reset after the I grant.
- Abort:
  - Fetch in WAIT, pulse i_abort, then m_rvalid.
  - Expect i_rvalid=0 throughout, state returns to IDLE, and a following d_valid is granted normally.
- Stalling memory:
  - m_ready low for 5 cycles.
  - Expect m_valid high and m_addr/m_wdata unchanged every cycle; the same-cycle m_ready+m_rvalid path delivers the response.
- Async reset mid-WAIT:
  - Assert reset between edges.
  - Expect all outputs 0 immediately; a stale m_rvalid after reset release produces no i_rvalid/d_rvalid.
